// File: rtl/spmm_rhs_loader_if.sv
// Handshake and data bus between the RHS tile loader, its upstream source
// and the SpMM PE array.
//   rhs_ready/rhs_start/rhs_data : tile input, 4 rows per beat
//   mat_valid/mat_take/ws_hold   : read-bank handshake
//   mat_data                     : read bank, mat_data[col][row]
// The slave modport is the loader; master is the source/consumer side.
interface spmm_rhs_loader_if #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 8
) ();
  logic                             rhs_ready;
  logic                             rhs_start;
  logic [3:0][N-1:0][W-1:0]         rhs_data;
  logic                             mat_valid;
  logic                             mat_take;
  logic                             ws_hold;
  logic [N-1:0][N-1:0][W-1:0]       mat_data;

  modport slave (
    output rhs_ready,
    input  rhs_start,
    input  rhs_data,
    output mat_valid,
    input  mat_take,
    input  ws_hold,
    output mat_data
  );

  modport master (
    input  rhs_ready,
    output rhs_start,
    output rhs_data,
    input  mat_valid,
    output mat_take,
    output ws_hold,
    input  mat_data
  );
endinterface

// File: rtl/spmm_rhs_loader.sv
// Double-buffered RHS tile loader for the SpMM PE array.
// Fills one bank 4 rows per beat (column-major storage) while the other bank
// is presented to the PE array; ws_hold lets the consumer reuse a tile.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   bus        : spmm_rhs_loader_if.slave (tile input + read-bank handshake)
//   loads_done : 16-bit saturating count of completed tile loads
//                (present only when SPMM_RHS_PERF_EN is defined)
module spmm_rhs_loader #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 8
) (
  input  logic                clock,
  input  logic                reset,
  spmm_rhs_loader_if.slave    bus
`ifdef SPMM_RHS_PERF_EN
  ,
  output logic [15:0]         loads_done
`endif
);

  localparam int unsigned BEATS = N / 4;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = $clog2(N);

  typedef enum logic {IDLE, LOAD} state_e;
  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      full_q, full_d;
  tile_t           bank_q [2];
  tile_t           bank_d [2];
`ifdef SPMM_RHS_PERF_EN
  logic [15:0]     loads_q, loads_d;
`endif

  logic            rdy_c;
  logic            accept_c;
  logic            wr_en_c;
  logic            last_c;
  logic [BW-1:0]   wr_beat_c;
  logic [RW-1:0]   row_base_c;
  logic [RW-1:0]   row_c;

  assign rdy_c = (state_q == IDLE) && !full_q[wr_ptr_q];

  // Next-state: fill side writes a beat, read side releases a bank
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    bank_d   = bank_q;
`ifdef SPMM_RHS_PERF_EN
    loads_d  = loads_q;
`endif
    row_c    = '0;

    accept_c   = bus.rhs_start && rdy_c;
    wr_en_c    = accept_c || (state_q == LOAD);
    wr_beat_c  = (state_q == LOAD) ? beat_q : '0;
    last_c     = wr_en_c && (wr_beat_c == BW'(BEATS - 1));
    row_base_c = RW'({wr_beat_c, 2'b00});

    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        row_c = row_base_c + RW'(i);
        for (int j = 0; j < N; j++) begin
          bank_d[wr_ptr_q][j][row_c] = bus.rhs_data[i][j];
        end
      end
    end

    if (accept_c && !last_c) begin
      state_d = LOAD;
      beat_d  = BW'(1);
    end else if ((state_q == LOAD) && !last_c) begin
      beat_d  = beat_q + BW'(1);
    end

    if (last_c) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = !wr_ptr_q;
      beat_d           = '0;
      state_d          = IDLE;
`ifdef SPMM_RHS_PERF_EN
      if (loads_q != 16'hFFFF) loads_d = loads_q + 16'd1;
`endif
    end

    // A full read bank is never the fill bank, so this cannot clash with the
    // completion above.
    if (bus.mat_take && full_q[rd_ptr_q] && !bus.ws_hold) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = !rd_ptr_q;
    end
  end

  // State and storage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= '0;
      bank_q   <= '{default: '0};
`ifdef SPMM_RHS_PERF_EN
      loads_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      bank_q   <= bank_d;
`ifdef SPMM_RHS_PERF_EN
      loads_q  <= loads_d;
`endif
    end
  end

  assign bus.rhs_ready = rdy_c;
  assign bus.mat_valid = full_q[rd_ptr_q];
  assign bus.mat_data  = bank_q[rd_ptr_q];
`ifdef SPMM_RHS_PERF_EN
  assign loads_done    = loads_q;
`endif

endmodule
